// File: rtl/ext_pipe_if.sv
// Operand-extender handshake bundle.
// Master drives operands and consumes results; slave is the extender.
interface ext_pipe_if #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_off;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_data, in_off, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_op, in_data, in_off, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/ext_pipe.sv
// Registered immediate/load-data extender with a two-entry skid buffer.
// Misaligned loads yield zero data with an error flag and are counted.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  ext_pipe_if.slave  io,
  output logic [7:0] err_cnt
);

  logic [IMM_W-1:0]  imm;
  logic [15:0]       lane;
  logic [DATA_W-1:0] res;
  logic              res_err;
  logic              in_fire;
  logic              out_free;
  logic              out_fire;
  logic              skid_v;
  logic              skid_nxt;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;

  assign imm      = io.in_data[IMM_W-1:0];
  assign lane     = 16'(io.in_data >> {io.in_off, 3'b000});
  assign in_fire  = io.in_valid && io.in_ready;
  assign out_free = !io.out_valid || io.out_ready;
  assign out_fire = io.out_valid && io.out_ready;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    unique case (io.in_op)
      3'b000: res = {{(DATA_W-IMM_W){1'b0}}, imm};
      3'b001: res = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      3'b010: res = {imm, {(DATA_W-IMM_W){1'b0}}};
      3'b011: res = {{(DATA_W-8){lane[7]}}, lane[7:0]};
      3'b100: res = {{(DATA_W-8){1'b0}}, lane[7:0]};
      // op bit 0 distinguishes signed (101) from unsigned (110) halves
      3'b101, 3'b110: begin
        if (io.in_off[0]) res_err = 1'b1;
        else res = {{(DATA_W-16){io.in_op[0] & lane[15]}}, lane};
      end
      3'b111: begin
        if (io.in_off != '0) res_err = 1'b1;
        else res = io.in_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    skid_nxt = skid_v;
    if (flush)         skid_nxt = 1'b0;
    else if (out_free) skid_nxt = 1'b0;
    else if (in_fire)  skid_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.out_err   <= 1'b0;
      io.in_ready  <= 1'b1;
      skid_v       <= 1'b0;
      skid_data    <= '0;
      skid_err     <= 1'b0;
      err_cnt      <= '0;
    end else if (flush) begin
      io.out_valid <= 1'b0;
      io.in_ready  <= 1'b1;
      skid_v       <= 1'b0;
    end else begin
      if (out_fire && io.out_err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (out_free) begin
        if (skid_v) begin
          io.out_valid <= 1'b1;
          io.out_data  <= skid_data;
          io.out_err   <= skid_err;
        end else if (in_fire) begin
          io.out_valid <= 1'b1;
          io.out_data  <= res;
          io.out_err   <= res_err;
        end else begin
          io.out_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_data <= res;
        skid_err  <= res_err;
      end
      skid_v      <= skid_nxt;
      io.in_ready <= !skid_nxt;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: directed vectors queue expected results,
// a negedge monitor pops and compares every output transfer.
module tb_ext_pipe;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] err_cnt;

  ext_pipe_if #(.DATA_W(32)) ifc ();

  ext_pipe #(.IMM_W(16), .DATA_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .io      (ifc.slave),
    .err_cnt (err_cnt)
  );

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          em_cnt = 0;
  bit          stalled = 0;
  logic [31:0] held_d;
  logic        held_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled && ifc.out_valid) begin
        n_vec++;
        if (ifc.out_data !== held_d || ifc.out_err !== held_e) begin
          n_bad++;
          $display("FAIL stall_hold: got %h/%b want %h/%b",
                   ifc.out_data, ifc.out_err, held_d, held_e);
        end
      end
      if (ifc.out_valid && ifc.out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: got %h/%b want none",
                   ifc.out_data, ifc.out_err);
        end else begin
          exp_t x;
          x = q.pop_front();
          if (x.e && em_cnt < 255) em_cnt++;
          if (ifc.out_data !== x.d || ifc.out_err !== x.e) begin
            n_bad++;
            $display("FAIL out_data: got %h/%b want %h/%b",
                     ifc.out_data, ifc.out_err, x.d, x.e);
          end
        end
      end
      stalled = ifc.out_valid && !ifc.out_ready;
      held_d  = ifc.out_data;
      held_e  = ifc.out_err;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] d,
                      input logic [1:0] off, input logic [31:0] ed,
                      input logic ee, input bit lat);
    int w;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_data  = d;
    ifc.in_off   = off;
    w = 0;
    while (!ifc.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ifc.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
      ifc.in_valid = 1'b0;
      return;
    end
    q.push_back('{ed, ee});
    @(posedge clk);
    #1;
    if (lat) begin
      n_vec++;
      if (!(ifc.out_valid && ifc.out_data === ed && ifc.out_err === ee)) begin
        n_bad++;
        $display("FAIL latency: got v=%b %h/%b want v=1 %h/%b",
                 ifc.out_valid, ifc.out_data, ifc.out_err, ed, ee);
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_op     = 3'b000;
    ifc.in_data   = '0;
    ifc.in_off    = '0;
    ifc.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_data", ifc.out_data, 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    send(3'b000, 32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0, 1);
    send(3'b001, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0, 1);
    send(3'b010, 32'h0000_8001, 2'd3, 32'h8001_0000, 1'b0, 1);

    send(3'b011, 32'h80FF_7F01, 2'd1, 32'h0000_007F, 1'b0, 1);
    send(3'b011, 32'h80FF_7F01, 2'd3, 32'hFFFF_FF80, 1'b0, 1);
    send(3'b100, 32'h80FF_7F01, 2'd2, 32'h0000_00FF, 1'b0, 1);
    send(3'b101, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF, 1'b0, 1);
    send(3'b110, 32'h80FF_7F01, 2'd0, 32'h0000_7F01, 1'b0, 1);
    send(3'b111, 32'h80FF_7F01, 2'd0, 32'h80FF_7F01, 1'b0, 1);
    idle(2);
    drain();

    send(3'b101, 32'h80FF_7F01, 2'd1, 32'h0, 1'b1, 1);
    idle(2);
    drain();
    chk("err_cnt_1", 32'(err_cnt), 32'd1);
    send(3'b111, 32'h80FF_7F01, 2'd2, 32'h0, 1'b1, 1);
    idle(2);
    drain();
    chk("err_cnt_2", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 300; i++)
      send(3'b111, 32'h1234_5678, 2'd1, 32'h0, 1'b1, 0);
    idle(2);
    drain();
    idle(2);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    chk("err_cnt_model", 32'(err_cnt), 32'(em_cnt));

    @(negedge clk);
    ifc.out_ready = 1'b0;
    fork
      begin
        send(3'b000, 32'h0000_000A, 2'd0, 32'h0000_000A, 1'b0, 0);
        send(3'b000, 32'h0000_000B, 2'd0, 32'h0000_000B, 1'b0, 0);
        send(3'b000, 32'h0000_000C, 2'd0, 32'h0000_000C, 1'b0, 0);
        send(3'b000, 32'h0000_000D, 2'd0, 32'h0000_000D, 1'b0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
        chk("bp_out_data", ifc.out_data, 32'h0000_000A);
        chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
        ifc.out_ready = 1'b1;
      end
    join
    idle(2);
    drain();

    @(negedge clk);
    ifc.out_ready = 1'b0;
    send(3'b000, 32'h0000_1234, 2'd0, 32'h0000_1234, 1'b0, 0);
    send(3'b000, 32'h0000_5678, 2'd0, 32'h0000_5678, 1'b0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("arst_out_data", ifc.out_data, 32'd0);
    chk("arst_out_err", 32'(ifc.out_err), 32'd0);
    chk("arst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    q.delete();
    em_cnt = 0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    send(3'b001, 32'h0000_7FFF, 2'd0, 32'h0000_7FFF, 1'b0, 1);
    send(3'b111, 32'h0000_0000, 2'd3, 32'h0, 1'b1, 1);
    idle(2);
    drain();
    chk("err_cnt_post_rst", 32'(err_cnt), 32'd1);

    @(negedge clk);
    ifc.out_ready = 1'b0;
    send(3'b111, 32'hDEAD_BEEF, 2'd1, 32'h0, 1'b1, 0);
    send(3'b110, 32'hDEAD_BEEF, 2'd3, 32'h0, 1'b1, 0);
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_op    = 3'b111;
    ifc.in_data  = 32'hCAFE_F00D;
    ifc.in_off   = 2'd2;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    ifc.in_valid = 1'b0;
    q.delete();
    chk("flush_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("flush_in_ready", 32'(ifc.in_ready), 32'd1);
    @(negedge clk);
    ifc.out_ready = 1'b1;
    idle(4);
    chk("flush_err_cnt", 32'(err_cnt), 32'd1);
    chk("flush_quiet", 32'(ifc.out_valid), 32'd0);
    send(3'b100, 32'h0000_A500, 2'd1, 32'h0000_00A5, 1'b0, 1);
    idle(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
